onewire_rx: RTL and testbench

//  Slave-side 1-Wire frame receiver; the counterpart of the master transmitter on the shared open-drain bus.

---
 rtl/onewire_pkg.sv | 12 +
 rtl/crc8_serial.sv | 23 ++
 rtl/onewire_rx.sv | 121 ++++++++++++
 tb/tb_onewire_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared constants and FSM encoding for the 1-Wire slave receiver.
package onewire_pkg;
  localparam int         FRAME_BITS = 64;
  localparam int         DATA_BITS  = 56;
  localparam int         CNT_W      = 11;
  localparam logic [7:0] CRC_POLY   = 8'h31;

  typedef enum logic [3:0] {
    S_IDLE, S_RST_LOW, S_PRES_WAIT, S_PRES_DRIVE, S_REL_WAIT,
    S_SLOT_WAIT, S_SAMPLE, S_SLOT_END, S_DONE
  } state_t;
endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (x^8+x^5+x^4+1), MSB first, init 0.
module crc8_serial
  import onewire_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_bit,
  input  logic       i_en,
  output logic [7:0] o_crc
);
  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb  = r_crc[7] ^ i_bit;
  assign o_crc = r_crc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_crc <= 8'h00;
    else if (i_clear) r_crc <= 8'h00;
    else if (i_en)    r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
  end
endmodule

// File: rtl/onewire_rx.sv
// 1-Wire slave frame receiver: reset/presence handshake, 64 write slots, CRC check.
module onewire_rx
  import onewire_pkg::*;
#(
  parameter int RST_MIN_CYC  = 400,
  parameter int PRES_DLY_CYC = 30,
  parameter int PRES_LEN_CYC = 120,
  parameter int SAMPLE_CYC   = 15,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  inout  wire                  bus,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_crc_err,
  output logic                 o_rx_abort,
  output logic                 o_rx_busy
);
  localparam logic [CNT_W-1:0] L_RST = CNT_W'(RST_MIN_CYC);
  localparam logic [CNT_W-1:0] L_DLY = CNT_W'(PRES_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] L_LEN = CNT_W'(PRES_LEN_CYC - 1);
  localparam logic [CNT_W-1:0] L_SMP = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] L_TO  = CNT_W'(TIMEOUT_CYC - 1);

  state_t                r_state, w_nxt;
  logic                  r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0]      r_cnt;
  logic [6:0]            r_bits;
  logic [FRAME_BITS-1:0] r_frame;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid, r_err, r_abort;
  logic                  w_fall, w_cnt_clr, w_sample, w_crc_clr, w_done, w_abort;
  logic [7:0]            w_crc;

  // Presence drive is decoded straight from state so an async reset frees the bus at once.
  assign bus        = (r_state == S_PRES_DRIVE) ? 1'b0 : 1'bz;
  assign w_fall     = r_prev & ~r_sync2;
  assign o_rx_busy  = (r_state inside {S_PRES_WAIT, S_PRES_DRIVE, S_REL_WAIT,
                                       S_SLOT_WAIT, S_SAMPLE, S_SLOT_END});
  assign o_rx_data  = r_data;
  assign o_rx_valid = r_valid;
  assign o_crc_err  = r_err;
  assign o_rx_abort = r_abort;

  crc8_serial u_crc (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_crc_clr),
    .i_bit   (r_sync2),
    .i_en    (w_sample),
    .o_crc   (w_crc)
  );

  always_comb begin
    w_nxt     = r_state;
    w_cnt_clr = 1'b0;
    w_sample  = 1'b0;
    w_crc_clr = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE:       if (w_fall) begin w_nxt = S_RST_LOW; w_cnt_clr = 1'b1; end
      S_RST_LOW:    if (r_sync2) begin
                      w_nxt     = (r_cnt >= L_RST) ? S_PRES_WAIT : S_IDLE;
                      w_cnt_clr = 1'b1;
                    end
      S_PRES_WAIT:  if (r_cnt == L_DLY) begin w_nxt = S_PRES_DRIVE; w_cnt_clr = 1'b1; end
      S_PRES_DRIVE: if (r_cnt == L_LEN) begin w_nxt = S_REL_WAIT; w_cnt_clr = 1'b1; end
      S_REL_WAIT:   if (r_sync2) begin
                      w_nxt = S_SLOT_WAIT; w_cnt_clr = 1'b1; w_crc_clr = 1'b1;
                    end
      S_SLOT_WAIT:  if (w_fall) begin w_nxt = S_SAMPLE; w_cnt_clr = 1'b1; end
                    else if (r_cnt >= L_TO) begin w_nxt = S_IDLE; w_abort = 1'b1; end
      S_SAMPLE:     if (r_cnt == L_SMP) begin w_nxt = S_SLOT_END; w_sample = 1'b1; end
      // Counter keeps running from the slot edge, so a long low here is a new reset.
      S_SLOT_END:   if (r_sync2) begin
                      if (r_bits == 7'(FRAME_BITS)) begin w_nxt = S_DONE; w_done = 1'b1; end
                      else begin w_nxt = S_SLOT_WAIT; w_cnt_clr = 1'b1; end
                    end else if (r_cnt >= L_RST) begin
                      w_nxt = S_RST_LOW; w_abort = 1'b1;
                    end
      S_DONE:       w_nxt = S_IDLE;
      default:      w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_frame <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_sync1 <= bus;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (w_crc_clr) begin
        r_bits  <= '0;
        r_frame <= '0;
      end else if (w_sample) begin
        r_bits  <= r_bits + 1'b1;
        r_frame <= {r_frame[FRAME_BITS-2:0], r_sync2};
      end
      r_valid <= w_done & (w_crc == 8'h00);
      r_err   <= w_done & (w_crc != 8'h00);
      r_abort <= w_abort;
      if (w_done && w_crc == 8'h00) r_data <= r_frame[FRAME_BITS-1:8];
    end
  end
endmodule

// File: tb/tb_onewire_rx.sv
// Directed bench: bus-functional 1-Wire master driving the slave receiver.
module tb_onewire_rx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_low = 1'b0;
  wire         bus;
  logic [55:0] o_rx_data;
  logic        o_rx_valid, o_crc_err, o_rx_abort, o_rx_busy;

  int n_tests = 0, n_fail = 0;
  int n_valid = 0, n_err = 0, n_abort = 0, n_busy = 0;

  assign bus = m_low ? 1'b0 : 1'bz;
  pullup (bus);

  always #5 clk = ~clk;

  onewire_rx dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_rx_data  (o_rx_data),
    .o_rx_valid (o_rx_valid),
    .o_crc_err  (o_crc_err),
    .o_rx_abort (o_rx_abort),
    .o_rx_busy  (o_rx_busy)
  );

  always @(negedge clk) begin
    n_valid <= n_valid + int'(o_rx_valid);
    n_err   <= n_err   + int'(o_crc_err);
    n_abort <= n_abort + int'(o_rx_abort);
    n_busy  <= n_busy  + int'(o_rx_busy);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [55:0] d);
    logic [7:0] c = 8'h00;
    logic       fb;
    for (int i = 55; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
    end
    return c;
  endfunction

  // Master reset pulse, then measure the slave presence pulse length.
  task automatic do_reset(input int len, output int pres);
    int t;
    m_low = 1'b1;
    repeat (len) @(posedge clk);
    m_low = 1'b0;
    pres = 0;
    t = 0;
    @(negedge clk);
    while (bus !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    while (bus === 1'b0 && pres < 400) begin pres++; @(negedge clk); end
    repeat (10) @(posedge clk);
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    repeat (b ? 6 : 60) @(posedge clk);
    m_low = 1'b0;
    repeat (b ? 64 : 10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [55:0] d, input logic [7:0] flip);
    logic [63:0] f;
    f = {d, crc8(d) ^ flip};
    for (int i = 63; i >= 0; i--) write_bit(f[i]);
    repeat (5) @(posedge clk);
  endtask

  initial begin
    int pres, v0, e0, a0, b0;
    logic [55:0] d1, d4;
    d1 = 56'h00_1234_5678_9ABC;
    d4 = 56'hA5_5A0F_F012_3456;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data",  {8'h0, o_rx_data}, 64'h0);
    chk("rst_flags", {60'h0, o_rx_valid, o_crc_err, o_rx_abort, o_rx_busy}, 64'h0);
    chk("rst_bus",   {63'h0, bus}, 64'h1);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // 1: good frame
    do_reset(480, pres);
    chk("t1_pres", 64'(pres), 64'd120);
    chk("t1_busy", {63'h0, o_rx_busy}, 64'h1);
    v0 = n_valid; e0 = n_err;
    send_frame(d1, 8'h00);
    chk("t1_valid", 64'(n_valid - v0), 64'd1);
    chk("t1_err",   64'(n_err - e0), 64'd0);
    chk("t1_data",  {8'h0, o_rx_data}, {8'h0, d1});
    chk("t1_idle",  {63'h0, o_rx_busy}, 64'h0);

    // 2: CRC bit 0 flipped
    do_reset(480, pres);
    v0 = n_valid; e0 = n_err;
    send_frame(56'h00_1234_5678_9ABD, 8'h01);
    chk("t2_err",   64'(n_err - e0), 64'd1);
    chk("t2_valid", 64'(n_valid - v0), 64'd0);
    chk("t2_hold",  {8'h0, o_rx_data}, {8'h0, d1});

    // 3: short low pulse is not a reset
    b0 = n_busy;
    do_reset(300, pres);
    chk("t3_pres", 64'(pres), 64'd0);
    chk("t3_busy", 64'(n_busy - b0), 64'd0);

    // 4: reset mid-frame, then a full frame
    do_reset(480, pres);
    a0 = n_abort;
    for (int i = 0; i < 20; i++) write_bit(1'(i % 2));
    do_reset(480, pres);
    chk("t4_abort", 64'(n_abort - a0), 64'd1);
    chk("t4_pres",  64'(pres), 64'd120);
    v0 = n_valid;
    send_frame(d4, 8'h00);
    chk("t4_valid", 64'(n_valid - v0), 64'd1);
    chk("t4_data",  {8'h0, o_rx_data}, {8'h0, d4});

    // 5: timeout between slots
    do_reset(480, pres);
    a0 = n_abort;
    for (int i = 0; i < 10; i++) write_bit(1'(i % 3 == 0));
    repeat (1100) @(posedge clk);
    @(negedge clk);
    chk("t5_abort", 64'(n_abort - a0), 64'd1);
    chk("t5_busy",  {63'h0, o_rx_busy}, 64'h0);
    chk("t5_hold",  {8'h0, o_rx_data}, {8'h0, d4});

    // 6: async reset while presence is being driven
    m_low = 1'b1;
    repeat (480) @(posedge clk);
    m_low = 1'b0;
    pres = 0;
    @(negedge clk);
    while (bus !== 1'b0 && pres < 200) begin @(negedge clk); pres++; end
    chk("t6_presstart", {63'h0, bus}, 64'h0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    @(negedge clk);
    chk("t6_bus",   {63'h0, bus}, 64'h1);
    chk("t6_flags", {60'h0, o_rx_valid, o_crc_err, o_rx_abort, o_rx_busy}, 64'h0);
    chk("t6_data",  {8'h0, o_rx_data}, 64'h0);
    reset = 1'b0;
    repeat (200) @(posedge clk);

    // 7: all-ones and all-zeros payloads
    do_reset(480, pres);
    v0 = n_valid;
    send_frame({56{1'b1}}, 8'h00);
    chk("t7_ones_valid", 64'(n_valid - v0), 64'd1);
    chk("t7_ones_data",  {8'h0, o_rx_data}, {8'h0, {56{1'b1}}});
    do_reset(480, pres);
    v0 = n_valid;
    send_frame(56'h0, 8'h00);
    chk("t7_zero_valid", 64'(n_valid - v0), 64'd1);
    chk("t7_zero_data",  {8'h0, o_rx_data}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
